// File: rtl/os_checker_multilane.sv
// Multi-lane TS1/TS2 ordered-set qualifier with per-lane consecutive-match counting for the LTSSM.
// Optional OS_CHECKER_ERRCNT_EN adds per-lane saturating non-match counters on err_cnt.
module os_checker_lane #(
  parameter int DEVICETYPE = 0,
  parameter int TARGET_CNT = 8,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_range,
  input  logic         chg,
  input  logic [3:0]   substate,
  input  logic [7:0]   link_number,
  input  logic [7:0]   lane_number,
  input  logic [127:0] os,
  input  logic         valid,
  output logic         done,
  output logic         acc
`ifdef OS_CHECKER_ERRCNT_EN
  , output logic [7:0] err_cnt
`endif
);
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] TS1 = 8'h2A;
  localparam logic [7:0] TS2 = 8'h25;

  typedef enum logic [1:0] {IDLE, HUNT, COUNT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       ref_rate_q, ref_rate_d;
  logic             ref_b42_q, ref_b42_d;
  logic [7:0]       f_link, f_lane, f_rate, f_id;
  logic             f_b42, f_b43;
  logic             link_pad, lane_pad, link_ok, lane_ok, is_ts1, is_ts2;
  logic             match, same_ref;
  logic             unused_os;

  assign f_link    = os[15:8];
  assign f_lane    = os[23:16];
  assign f_rate    = os[39:32];
  assign f_b42     = os[42];
  assign f_b43     = os[43];
  assign f_id      = os[87:80];
  assign unused_os = ^{os[127:88], os[79:44], os[41:40], os[31:24], os[7:0]};

  assign link_pad = (f_link == PAD);
  assign lane_pad = (f_lane == PAD);
  assign link_ok  = (f_link == link_number);
  assign lane_ok  = (f_lane == lane_number);
  assign is_ts1   = (f_id == TS1);
  assign is_ts2   = (f_id == TS2);
  assign same_ref = (f_rate == ref_rate_q) && (f_b42 == ref_b42_q);

  always_comb begin
    match = 1'b0;
    case (substate)
      4'd2:       match = link_pad && lane_pad && (is_ts2 || (is_ts1 && (!f_b43 || f_b42)));
      4'd3:       match = link_pad && lane_pad && is_ts2;
      4'd4:       match = lane_pad && is_ts1 && ((DEVICETYPE == 0) ? link_ok : !link_pad);
      4'd5:       match = link_ok && !lane_pad && is_ts1;
      4'd6, 4'd7: match = link_ok && lane_ok && ((DEVICETYPE == 0) ? is_ts1 : is_ts2);
      4'd8:       match = link_ok && lane_ok && is_ts2;
      default:    match = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ref_rate_d = ref_rate_q;
    ref_b42_d  = ref_b42_q;
    acc        = 1'b0;
    if (!en || !in_range) begin
      state_d    = IDLE;
      cnt_d      = '0;
      ref_rate_d = '0;
      ref_b42_d  = 1'b0;
    end else if (chg || state_q == IDLE) begin
      // substate change discards any ordered set presented this cycle
      state_d    = HUNT;
      cnt_d      = '0;
      ref_rate_d = '0;
      ref_b42_d  = 1'b0;
    end else begin
      case (state_q)
        HUNT: if (valid && match) begin
          acc        = 1'b1;
          state_d    = COUNT;
          cnt_d      = CNT_W'(1);
          ref_rate_d = f_rate;
          ref_b42_d  = f_b42;
        end
        COUNT: if (valid) begin
          if (match) begin
            acc        = 1'b1;
            ref_rate_d = f_rate;
            ref_b42_d  = f_b42;
            // cfgComplete inconsistency restarts the run with this set as the new reference
            if (substate == 4'd8 && !same_ref) begin
              cnt_d = CNT_W'(1);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == CNT_W'(TARGET_CNT)) state_d = DONE;
            end
          end else begin
            state_d = HUNT;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ref_rate_q <= '0;
      ref_b42_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_rate_q <= ref_rate_d;
      ref_b42_q  <= ref_b42_d;
    end
  end

  assign done = (state_q == DONE);

`ifdef OS_CHECKER_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (chg) begin
      err_d = '0;
    end else if (en && valid && !match && (state_q == HUNT || state_q == COUNT) && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif
endmodule

module os_checker_multilane #(
  parameter int LANES      = 4,
  parameter int DEVICETYPE = 0,
  parameter int TARGET_CNT = 8,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           substate,
  input  logic [7:0]           link_number,
  input  logic [8*LANES-1:0]   lane_number,
  input  logic [LANES-1:0]     lane_en,
  input  logic [128*LANES-1:0] orderedset,
  input  logic [LANES-1:0]     valid,
  output logic [LANES-1:0]     lane_done,
  output logic                 all_done,
  output logic [7:0]           rateid,
  output logic                 upconfigure_capability
`ifdef OS_CHECKER_ERRCNT_EN
  , output logic [8*LANES-1:0] err_cnt
`endif
);
  logic [3:0]       substate_q;
  logic             all_done_q, all_done_d;
  logic [7:0]       rateid_q, rateid_d;
  logic             upcfg_q, upcfg_d;
  logic             in_range, chg, found;
  logic [LANES-1:0] done_w, acc_w;

  assign in_range = (substate >= 4'd2) && (substate <= 4'd8);
  assign chg      = (substate != substate_q);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    os_checker_lane #(
      .DEVICETYPE(DEVICETYPE),
      .TARGET_CNT(TARGET_CNT),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .en         (lane_en[i]),
      .in_range   (in_range),
      .chg        (chg),
      .substate   (substate),
      .link_number(link_number),
      .lane_number(lane_number[8*i +: 8]),
      .os         (orderedset[128*i +: 128]),
      .valid      (valid[i]),
      .done       (done_w[i]),
      .acc        (acc_w[i])
`ifdef OS_CHECKER_ERRCNT_EN
      , .err_cnt  (err_cnt[8*i +: 8])
`endif
    );
  end

  assign all_done_d = (|lane_en) && (&(done_w | ~lane_en));

  // capability fields track only the lowest-index enabled lane
  always_comb begin
    rateid_d = rateid_q;
    upcfg_d  = upcfg_q;
    found    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!found && lane_en[i]) begin
        found = 1'b1;
        if (acc_w[i]) begin
          rateid_d = orderedset[128*i+32 +: 8];
          upcfg_d  = orderedset[128*i+42];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      substate_q <= '0;
      all_done_q <= 1'b0;
      rateid_q   <= '0;
      upcfg_q    <= 1'b0;
    end else begin
      substate_q <= substate;
      all_done_q <= all_done_d;
      rateid_q   <= rateid_d;
      upcfg_q    <= upcfg_d;
    end
  end

  assign lane_done              = done_w;
  assign all_done               = all_done_q;
  assign rateid                 = rateid_q;
  assign upconfigure_capability = upcfg_q;
endmodule

// File: tb/tb_os_checker_multilane.sv
// Directed bench for os_checker_multilane: a downstream and an upstream instance share stimulus.
module tb_os_checker_multilane;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] TS1 = 8'h2A;
  localparam logic [7:0] TS2 = 8'h25;
  localparam logic [7:0] LNK = 8'h11;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   substate;
  logic [7:0]   link_number;
  logic [31:0]  lane_number;
  logic [3:0]   lane_en;
  logic [511:0] orderedset;
  logic [3:0]   valid;
  logic [3:0]   dn_done, up_done;
  logic         dn_all, up_all;
  logic [7:0]   dn_rate, up_rate;
  logic         dn_upc, up_upc;
`ifdef OS_CHECKER_ERRCNT_EN
  logic [31:0]  dn_err, up_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  os_checker_multilane #(.LANES(4), .DEVICETYPE(0), .TARGET_CNT(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .substate(substate), .link_number(link_number),
    .lane_number(lane_number), .lane_en(lane_en), .orderedset(orderedset), .valid(valid),
    .lane_done(dn_done), .all_done(dn_all), .rateid(dn_rate), .upconfigure_capability(dn_upc)
`ifdef OS_CHECKER_ERRCNT_EN
    , .err_cnt(dn_err)
`endif
  );

  os_checker_multilane #(.LANES(4), .DEVICETYPE(1), .TARGET_CNT(8), .CNT_W(8)) dut_up (
    .clk(clk), .reset(reset), .substate(substate), .link_number(link_number),
    .lane_number(lane_number), .lane_en(lane_en), .orderedset(orderedset), .valid(valid),
    .lane_done(up_done), .all_done(up_all), .rateid(up_rate), .upconfigure_capability(up_upc)
`ifdef OS_CHECKER_ERRCNT_EN
    , .err_cnt(up_err)
`endif
  );

  typedef struct {
    logic [3:0] sub;
    logic [3:0] en;
    logic [3:0] vld;
    logic [3:0] badlane;
    logic [7:0] link;
    logic [7:0] id;
    logic [3:0] exp_done;
    logic       exp_all;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [3:0] sub, en, vld, badlane, input logic [7:0] link, id,
                              input logic [3:0] exp_done, input logic exp_all);
    vec_t v;
    v.sub = sub; v.en = en; v.vld = vld; v.badlane = badlane;
    v.link = link; v.id = id; v.exp_done = exp_done; v.exp_all = exp_all;
    vt.push_back(v);
  endfunction

  function automatic logic [127:0] mk_os(input logic [7:0] link, lane, rate, input logic b42, b43,
                                         input logic [7:0] id);
    logic [127:0] o;
    o = '0;
    o[7:0] = 8'hBC;
    o[15:8] = link;
    o[23:16] = lane;
    o[39:32] = rate;
    o[42] = b42;
    o[43] = b43;
    o[87:80] = id;
    return o;
  endfunction

  task automatic drive_all(input logic [7:0] link, input logic lpad, input logic [3:0] badl,
                           input logic [7:0] rate, input logic b42, b43, input logic [7:0] id);
    logic [7:0] lb;
    for (int i = 0; i < 4; i++) begin
      lb = lpad ? PAD : lane_number[8*i +: 8];
      if (badl[i]) lb = lb - 8'd1;
      orderedset[128*i +: 128] = mk_os(link, lb, rate, b42, b43, id);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; substate = 4'd0; link_number = LNK;
    lane_number = {8'd3, 8'd5, 8'd1, 8'd0};
    lane_en = 4'hF; valid = 4'h0; orderedset = '0;
    step; step;
    chk("rst_done", {28'd0, dn_done}, 32'd0);
    chk("rst_all", {31'd0, dn_all}, 32'd0);
    chk("rst_rate", {24'd0, dn_rate}, 32'd0);
    chk("rst_upc", {31'd0, dn_upc}, 32'd0);
    reset = 1'b1;

    // polling.active: 8 TS1 on all lanes; then cfg.lanenum.wait with lane 2 disabled and misnumbered
    add(4'd2, 4'hF, 4'h0, 4'h0, PAD, TS1, 4'h0, 1'b0);
    for (int k = 1; k <= 8; k++) add(4'd2, 4'hF, 4'hF, 4'h0, PAD, TS1, (k == 8) ? 4'hF : 4'h0, 1'b0);
    add(4'd2, 4'hF, 4'h0, 4'h0, PAD, TS1, 4'hF, 1'b1);
    add(4'd6, 4'hB, 4'h0, 4'h4, LNK, TS1, 4'h0, 1'b1);
    for (int k = 1; k <= 10; k++) add(4'd6, 4'hB, 4'hF, 4'h4, LNK, TS1, (k >= 8) ? 4'hB : 4'h0, k >= 9);

    foreach (vt[r]) begin
      substate = vt[r].sub; lane_en = vt[r].en; valid = vt[r].vld;
      drive_all(vt[r].link, vt[r].link == PAD, vt[r].badlane, 8'h01, 1'b0, 1'b0, vt[r].id);
      step;
      chk($sformatf("vec%0d_done", r), {28'd0, dn_done}, {28'd0, vt[r].exp_done});
      chk($sformatf("vec%0d_all", r), {31'd0, dn_all}, {31'd0, vt[r].exp_all});
    end

    // polling.configuration: a TS1 in the middle of lane 1's run clears its count
    lane_en = 4'hF; substate = 4'd3; valid = 4'h0; step;
    valid = 4'h2;
    drive_all(PAD, 1'b1, 4'h0, 8'h01, 1'b0, 1'b0, TS2);
    for (int k = 0; k < 5; k++) step;
    drive_all(PAD, 1'b1, 4'h0, 8'h01, 1'b0, 1'b0, TS1); step;
    drive_all(PAD, 1'b1, 4'h0, 8'h01, 1'b0, 1'b0, TS2);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("s3_ts2_%0d", k), {31'd0, dn_done[1]}, {31'd0, k == 8});
    end

    // cfg.linkwidth.start: any non-PAD link accepted only by the upstream port
    substate = 4'd4; valid = 4'h0; step;
    valid = 4'hF;
    drive_all(8'h22, 1'b1, 4'h0, 8'h01, 1'b0, 1'b0, TS1);
    for (int k = 0; k < 8; k++) step;
    chk("s4_up_done", {28'd0, up_done}, 32'hF);
    chk("s4_dn_done", {28'd0, dn_done}, 32'h0);

    // cfg.complete on the upstream port: rate change restarts the run
    substate = 4'd8; valid = 4'h0; step;
    valid = 4'h1;
    drive_all(LNK, 1'b0, 4'h0, 8'h03, 1'b0, 1'b0, TS2);
    for (int k = 0; k < 4; k++) step;
    chk("s8_rate03", {24'd0, up_rate}, 32'h03);
    drive_all(LNK, 1'b0, 4'h0, 8'h07, 1'b1, 1'b0, TS2);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("s8_r07_%0d", k), {31'd0, up_done[0]}, {31'd0, k == 8});
    end
    chk("s8_rate07", {24'd0, up_rate}, 32'h07);
    chk("s8_upc", {31'd0, up_upc}, 32'd1);

    // lanenum.accept done, then 7->8 together with a valid that must be discarded
    substate = 4'd7; valid = 4'h0; step;
    valid = 4'hF;
    drive_all(LNK, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0, TS1);
    for (int k = 0; k < 8; k++) step;
    chk("s7_done", {28'd0, dn_done}, 32'hF);
    substate = 4'd8;
    drive_all(LNK, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0, TS2);
    step;
    chk("s78_clear", {28'd0, dn_done}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("s8_dn_%0d", k), {28'd0, dn_done}, (k == 8) ? 32'hF : 32'h0);
    end

    // mid-count reset
    substate = 4'd2; valid = 4'h0; step;
    valid = 4'hF;
    drive_all(PAD, 1'b1, 4'h0, 8'h02, 1'b1, 1'b0, TS1);
    for (int k = 0; k < 5; k++) step;
    chk("pre_rst_rate", {24'd0, dn_rate}, 32'h02);
    chk("pre_rst_upc", {31'd0, dn_upc}, 32'd1);
    reset = 1'b0; step;
    chk("mid_rst_done", {28'd0, dn_done}, 32'h0);
    chk("mid_rst_all", {31'd0, dn_all}, 32'h0);
    chk("mid_rst_rate", {24'd0, dn_rate}, 32'h0);
    chk("mid_rst_upc", {31'd0, dn_upc}, 32'h0);
    reset = 1'b1; valid = 4'h0; step;
    valid = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step;
      chk($sformatf("post_rst_%0d", k), {28'd0, dn_done}, (k == 8) ? 32'hF : 32'h0);
    end

`ifdef OS_CHECKER_ERRCNT_EN
    substate = 4'd3; valid = 4'h0; step;
    valid = 4'hF;
    drive_all(PAD, 1'b1, 4'h0, 8'h01, 1'b0, 1'b0, TS1);
    for (int k = 0; k < 5; k++) step;
    chk("err_5", dn_err, 32'h05050505);
    for (int k = 0; k < 295; k++) step;
    chk("err_sat", dn_err, 32'hFFFFFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/os_checker_multilane.md
Name: os_checker_multilane

Overview:
- Parametrised, multi-lane successor to the single-lane ordered-set checker in the RX LTSSM.
- Each lane independently qualifies incoming TS1/TS2 ordered sets against rules chosen by the current LTSSM substate and device type.
- Each lane counts consecutive matches up to a programmable target and reports per-lane and link-wide completion.
- The LTSSM uses these flags instead of external countup/resetcounter counters. The block also captures the advertised rate ID and upconfigure capability.

Parameters:
- LANES, 4, number of lanes checked in parallel (1..16).
- DEVICETYPE, 0, 0 = downstream port, 1 = upstream port.
- TARGET_CNT, 8, consecutive matching ordered sets required per lane (2..255).
- CNT_W, 8, lane counter width; must satisfy 2^CNT_W > TARGET_CNT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- substate  in  4  LTSSM substate: 0 detectQuiet, 1 detectActive, 2 pollingActive, 3 pollingConfiguration, 4 cfgLinkWidthStart, 5 cfgLinkWidthAccept, 6 cfgLanenumWait, 7 cfgLanenumAccept, 8 cfgComplete, 9 cfgIdle.
- link_number  in  8  expected link number.
- lane_number  in  8*LANES  expected lane number per lane; lane i at [8i+7:8i].
- lane_en  in  LANES  lanes participating in the link.
- orderedset  in  128*LANES  one ordered set per lane; lane i at [128i+127:128i].
- valid  in  LANES  per-lane ordered-set strobe.
- lane_done  out  LANES  lane reached TARGET_CNT in the current substate.
- all_done  out  1  every enabled lane done, with at least one lane enabled.
- rateid  out  8  rate ID from the last matching ordered set of the lowest enabled lane.
- upconfigure_capability  out  1  bit 42 of the same ordered set.

Behaviour:
- Ordered-set fields per lane:
  - link byte [15:8], lane byte [23:16].
  - rate [39:32], bit 42, bit 43.
  - ID byte [87:80]: TS1 = 8'h2A, TS2 = 8'h25. PAD = 8'hF7.
- Match rule per substate (down = DEVICETYPE 0, up = DEVICETYPE 1):
  - 2: link==PAD, lane==PAD, and one of: TS2; TS1 with bit43==0; TS1 with bit42==1.
  - 3: link==PAD, lane==PAD, TS2.
  - 4 down: link==link_number, lane==PAD, TS1.
  - 4 up: link!=PAD, lane==PAD, TS1.
  - 5 (both types): link==link_number, lane!=PAD, TS1.
  - 6 and 7: link==link_number, lane==lane_number[i]; TS1 for down, TS2 for up.
  - 8: same link/lane check, TS2 required; also rate and bit42 must equal those of the previous matching ordered set on that lane.
  - All other substates: never match.
- Per-lane state machine:
  - States: IDLE, HUNT, COUNT, DONE.
  - IDLE: entered when substate is outside 2..8.
  - HUNT: entered when substate enters 2..8 or changes value; counter cleared.
  - HUNT -> COUNT on a matching valid ordered set; counter = 1.
  - COUNT, matching valid: counter +1. Reaching TARGET_CNT moves the lane to DONE.
  - COUNT, non-matching valid: back to HUNT, counter = 0.
  - COUNT, valid low: hold state and counter.
  - DONE: sticky until substate changes, reset, or lane_en[i] falls. Further ordered sets are ignored.
- Substate 8 consistency failure:
  - Restarts the count at 1; the new ordered set becomes the reference. No pass through HUNT.
  - The first match after HUNT only sets the reference.
- Timing:
  - Substate-change clearing wins over a simultaneous valid; that ordered set is discarded.
  - lane_done[i] rises the cycle after the TARGET_CNT-th matching valid edge.
  - all_done is registered and rises one cycle after the last enabled lane_done.
- Disabled lanes are held in IDLE and ignored by all_done.
- rateid/upconfigure_capability:
  - Update on every matching ordered set of the lowest-index enabled lane.
  - Hold otherwise, including across substate changes.
- Reset (reset==0 at clk edge):
  - All lanes to IDLE, counters and references 0.
  - lane_done, all_done, rateid, upconfigure_capability all 0.
  - Mid-operation reset aborts in one cycle.

Optional Feature:
- OS_CHECKER_ERRCNT_EN: adds output err_cnt (8*LANES).
  - One saturating 8-bit counter per lane, incremented on each non-matching valid ordered set while in HUNT or COUNT.
  - Cleared on substate change and on reset.
- Without the macro: port and logic absent; all other behaviour identical.

Test Plan:
- LANES=4, TARGET_CNT=8, substate=2, all lanes 8 consecutive TS1 (PAD,PAD, bit43=0) -> lane_done=4'hF on the cycle after the 8th; all_done one cycle later.
- substate=3, lane 1 sends 5 TS2, one TS1, then 8 TS2 -> lane 1 counter drops to 0 on the TS1; lane_done[1] only after the final 8th TS2.
- DEVICETYPE=1, substate=8, lane 0 TS2 rate 8'h03 x4, then rate 8'h07 x8 -> count restarts at 1 on the rate change; done after 8 at rate 07; rateid=8'h07.
- substate=6, lane_number lane 2 = 8'h05, lane 2 receives lane byte 8'h04 x10 -> lane_done[2]=0; with lane_en=4'b1011, all_done=1 once lanes 0, 1, 3 are done.
- Substate changes 7->8 in the same cycle as valid on a lane done in 7 -> lane_done cleared next cycle; that ordered set not counted.
- reset low for one cycle while lanes are counting at 5 -> all outputs 0; counts restart from HUNT. With OS_CHECKER_ERRCNT_EN, 300 bad ordered sets -> err_cnt lane = 8'hFF.
